uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, line bit rate in bit/s.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries; legal values are powers of two from 2 to 16.
REQ-004 SHALL have port sysclk  input  1  single clock; all logic updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; it is synchronous and active-high.
REQ-006 SHALL have port tx_data  input  8  byte to transmit.
REQ-007 SHALL have port tx_valid  input  1  producer offers tx_data this cycle.
REQ-008 SHALL have port tx_ready  output  1  buffer can accept a byte this cycle.
REQ-009 SHALL have port UART_TX  output  1  serial line; idle level is high.
REQ-010 SHALL have port tx_busy  output  1  high while a frame is on the line or the buffer is non-empty.
REQ-011 SHALL have port fifo_count  output  5  number of bytes buffered, excluding the frame in flight.

Function
REQ-012 SHALL derive bit period BAUD_DIV = (CLK_FREQ + BAUD/2) / BAUD sysclk cycles, giving 10417 at the defaults.
REQ-013 SHALL accept a byte on any rising edge where tx_valid and tx_ready are both high.
REQ-014 SHALL drive tx_ready = (fifo_count < FIFO_DEPTH); a same-cycle pop does not raise tx_ready.
REQ-015 SHALL run the FSM states IDLE, START, DATA, PARITY and STOP, where PARITY exists only per REQ-027.
REQ-016 SHALL pop one byte in IDLE when the buffer is non-empty, enter START and drive UART_TX low from the next edge.
  - Resulting latency: a byte accepted into an empty buffer while IDLE puts the start bit on the line 1 cycle after the accepting edge.
REQ-017 SHALL hold each bit for exactly BAUD_DIV cycles, counted by a bit-period counter that reloads at every bit boundary.
REQ-018 SHALL send the 8 data bits LSB first in DATA, tracked by a 3-bit index that wraps from 7 to exit the state.
REQ-019 SHALL drive UART_TX high for one bit period in STOP.
REQ-020 SHALL go at the end of STOP directly to START with the next byte if the buffer is non-empty (no idle gap), otherwise to IDLE.
REQ-021 SHALL ignore tx_data changes for the frame in flight, because the byte is latched into a shift register at pop.
REQ-022 SHALL handle a simultaneous accept and pop by leaving fifo_count unchanged and keeping FIFO order intact.
REQ-023 SHALL keep the UART_TX output registered, with no combinational path from any input to UART_TX.

Reset
REQ-024 SHALL, on reset, set UART_TX=1, tx_ready=1, tx_busy=0, fifo_count=0 and state IDLE, with counters cleared, at the next edge.
REQ-025 SHALL, on reset mid-frame, abort the frame: line high at the next edge, buffer flushed and the partial byte discarded.
REQ-026 SHALL give reset priority over a simultaneous tx_valid; that byte is not accepted.

Configuration
REQ-027 SHALL use macro UART_TX_PARITY_EN to control parity.
  - Defined: an even-parity bit (XOR of the 8 data bits) is sent in PARITY between DATA and STOP; a frame is 11 bit periods.
  - Undefined: no PARITY state; frame is 8N1, 10 bit periods, matching the existing CPU receive path.

Structure
REQ-028 SHALL place the FSM state enum, the BAUD_DIV computation function and the frame constants (DATA_BITS=8, STOP_BITS=1) in shared package uart_pkg, reused by the receiver.
REQ-029 SHALL implement the buffer as sub-module uart_tx_fifo: synchronous, first-word-fall-through, with push/pop/count.

Verification (bench overrides CLK_FREQ=16, BAUD=1, so BAUD_DIV=16)
REQ-030 SHALL cover: push 0x5A while idle -> 1 cycle later UART_TX runs 0,0,1,0,1,1,0,1,0,1, each level for 16 cycles, then idle high.
REQ-031 SHALL cover: push 0x00 then 0xFF back-to-back -> 20 contiguous bit periods with no idle between frames; tx_busy drops 1 cycle after the second stop bit ends.
REQ-032 SHALL cover: with the line busy, push 5 bytes at FIFO_DEPTH=4 -> tx_ready low after the 4th; the 5th is not accepted; fifo_count=4; all 4 bytes are sent in order.
REQ-033 SHALL cover: assert reset during data bit 3 of 0xA5 -> UART_TX=1 and fifo_count=0 at the next edge; no further start bit without a new push.
REQ-034 SHALL cover: with UART_TX_PARITY_EN defined, push 0x07 -> parity bit 1 between data bit 7 and the stop bit; push 0x03 -> parity bit 0.
REQ-035 SHALL cover: with default parameters, push 0x41 -> start bit lasts 10417 cycles, about 104170 ns.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, state encodings and baud divisor helper
`timescale 1ns/1ps
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    // Rounded to the nearest whole cycle so the rate error stays within half a clock.
    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous first-word-fall-through byte buffer with occupancy count
`timescale 1ns/1ps
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [4:0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q < 5'(DEPTH));
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - buffered UART transmitter, 8N1 by default; define UART_TX_PARITY_EN for an even-parity bit
`timescale 1ns/1ps
module uart_transmitter #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       UART_TX,
    output logic       tx_busy,
    output logic [4:0] fifo_count
);
    import uart_pkg::*;

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(BAUD_DIV - 1);

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             bit_done;
    logic             fifo_push, fifo_pop;
    logic [7:0]       fifo_head;

    assign tx_ready  = (fifo_count < 5'(FIFO_DEPTH));
    assign fifo_push = tx_valid && tx_ready && !reset;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (sysclk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    // tx_d is the level for the state being entered, so the line changes on the same edge as the state.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        bit_done   = (baud_cnt_q == '0);
        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_done ? BIT_RELOAD : baud_cnt_q - CNT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop   = 1'b1;
                    shreg_d    = fifo_head;
                    state_d    = ST_START;
                    tx_d       = 1'b0;
                    baud_cnt_d = BIT_RELOAD;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^shreg_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shreg_q[bit_idx_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (bit_idx_q == 3'(STOP_BITS - 1)) begin
                        bit_idx_d = '0;
                        if (fifo_count != '0) begin
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_head;
                            state_d  = ST_START;
                            tx_d     = 1'b0;
                        end else begin
                            state_d    = ST_IDLE;
                            tx_d       = 1'b1;
                            baud_cnt_d = '0;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_d       = 1'b1;
                baud_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
        end
    end

    assign UART_TX = tx_q;
    assign tx_busy = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
